// File: rtl/ann_weight_pkg.sv
// rtl/ann_weight_pkg.sv - shared geometry and fetch FSM encoding for weight BRAM wrappers and fetchers
package ann_weight_pkg;

  localparam int WEIGHT_DEPTH = 28;
  localparam int WEIGHT_AW    = 5;
  localparam int WEIGHT_DW    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/weight_skid_fifo.sv
// rtl/weight_skid_fifo.sv - 2-entry FIFO holding weight words tagged with address and last flag
module weight_skid_fifo
  import ann_weight_pkg::*;
#(
  parameter int AW = WEIGHT_AW,
  parameter int DW = WEIGHT_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic [AW-1:0] push_idx,
  input  logic          push_last,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [AW-1:0] idx,
  output logic          last,
  output logic          pop,
  output logic [1:0]    count
);

  localparam int EW = DW + AW + 1;

  // ent0 is always the head; ent1 only holds a word while count == 2
  logic [EW-1:0] ent0;
  logic [EW-1:0] ent1;
  logic [EW-1:0] din;

  assign din   = {push_last, push_idx, push_data};
  assign valid = (count != 2'd0);
  assign pop   = valid & ready;
  assign {last, idx, data} = ent0;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            ent0  <= din;
            count <= 2'd1;
          end else if (count == 2'd1) begin
            ent1  <= din;
            count <= 2'd2;
          end
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            ent0 <= din;
          end else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/weight_fetch_seq.sv
// rtl/weight_fetch_seq.sv - sweeps a weight BRAM 0..DEPTH-1 and streams tagged words to the MAC
module weight_fetch_seq
  import ann_weight_pkg::*;
#(
  parameter int DEPTH = WEIGHT_DEPTH,
  parameter int AW    = WEIGHT_AW,
  parameter int DW    = WEIGHT_DW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] BRAM_ADDR,
  output logic          BRAM_EN,
  output logic          BRAM_WE,
  output logic [DW-1:0] BRAM_DI,
  input  logic [DW-1:0] BRAM_DO,
  output logic [DW-1:0] W_DATA,
  output logic [AW-1:0] W_IDX,
  output logic          W_VALID,
  input  logic          W_READY,
  output logic          W_LAST
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  fetch_state_t  state, state_nxt;
  logic [AW-1:0] addr_q, addr_nxt;
  logic          en_q, en_nxt;
  logic [1:0]    occ;
  logic          pop;
  logic          head_last;
  logic [2:0]    load;
  logic          can_issue;

  // Credit check after this cycle's pop; the read in flight (en_q) lands next edge
  assign load      = {1'b0, occ} + {2'b00, en_q} - {2'b00, pop};
  assign can_issue = (load < 3'd2);

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    en_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          en_nxt    = 1'b1;
          addr_nxt  = '0;
          state_nxt = (DEPTH == 1) ? ST_DRAIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (can_issue) begin
          en_nxt   = 1'b1;
          addr_nxt = addr_q + 1'b1;
          if (addr_nxt == LAST_ADDR) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (DONE) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      en_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      en_q   <= en_nxt;
    end
  end

  weight_skid_fifo #(.AW(AW), .DW(DW)) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (en_q),
    .push_data (BRAM_DO),
    .push_idx  (addr_q),
    .push_last (addr_q == LAST_ADDR),
    .ready     (W_READY),
    .valid     (W_VALID),
    .data      (W_DATA),
    .idx       (W_IDX),
    .last      (head_last),
    .pop       (pop),
    .count     (occ)
  );

  assign BRAM_ADDR = addr_q;
  assign BRAM_EN   = en_q;
  assign BRAM_WE   = 1'b0;
  assign BRAM_DI   = '0;
  assign W_LAST    = W_VALID & head_last;
  assign DONE      = pop & head_last;
  assign BUSY      = (state != ST_IDLE);

endmodule

// File: tb/tb_weight_fetch_seq.sv
// tb/tb_weight_fetch_seq.sv - randomized self-checking bench for weight_fetch_seq
module tb_weight_fetch_seq;
  import ann_weight_pkg::*;

  localparam int DEPTH = WEIGHT_DEPTH;
  localparam int AW    = WEIGHT_AW;
  localparam int DW    = WEIGHT_DW;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic          BUSY, DONE, BRAM_EN, BRAM_WE, W_VALID, W_READY, W_LAST;
  logic [AW-1:0] BRAM_ADDR, W_IDX;
  logic [DW-1:0] BRAM_DI, BRAM_DO, W_DATA;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_mode = 0;

  logic [DW-1:0] mem [DEPTH];
  int exp_q[$];
  bit active = 1'b0;
  int start_cyc = 0, first_cyc = -1, done_cyc = -1;
  int words = 0, dones = 0, reads = 0;
  bit prev_stall = 1'b0;
  logic [AW-1:0] prev_idx;
  logic [DW-1:0] prev_data;
  bit hs, done_exp;
  int idx_exp;

  weight_fetch_seq dut (
    .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE), .BRAM_DI(BRAM_DI),
    .BRAM_DO(BRAM_DO), .W_DATA(W_DATA), .W_IDX(W_IDX), .W_VALID(W_VALID),
    .W_READY(W_READY), .W_LAST(W_LAST)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // BRAM behaviour: samples address/enable on the falling edge
  always @(negedge CLK) if (BRAM_EN) BRAM_DO <= mem[BRAM_ADDR];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Consumer: 0 hold high, 1 toggle, 2 random, 3 hold low
  initial begin
    W_READY = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      case (ready_mode)
        0: W_READY = 1'b1;
        1: W_READY = ~W_READY;
        2: W_READY = 1'($urandom_range(0, 1));
        default: W_READY = 1'b0;
      endcase
    end
  end

  // Reference model: an accepted sweep expects addresses 0..DEPTH-1 once each, in order
  always @(negedge CLK) begin
    if (RST) begin
      active = 1'b0;
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("we_zero", 32'(BRAM_WE), 0);
      chk("di_zero", 32'(BRAM_DI), 0);
      chk("busy", 32'(BUSY), 32'(active && cyc > start_cyc));
      if (prev_stall) begin
        chk("hold_valid", 32'(W_VALID), 1);
        chk("hold_idx", 32'(W_IDX), 32'(prev_idx));
        chk("hold_data", 32'(W_DATA), 32'(prev_data));
      end
      if (START && !active) begin
        active = 1'b1;
        start_cyc = cyc;
        first_cyc = -1;
        done_cyc = -1;
        words = 0;
        dones = 0;
        reads = 0;
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(i);
      end
      if (active && BRAM_EN) reads++;
      if (active && W_VALID && first_cyc < 0) first_cyc = cyc;
      hs = W_VALID && W_READY;
      done_exp = hs && (exp_q.size() == 1);
      chk("done", 32'(DONE), 32'(done_exp));
      if (DONE) begin
        dones++;
        done_cyc = cyc;
      end
      if (hs) begin
        if (exp_q.size() == 0) begin
          chk("spurious_word", 1, 0);
        end else begin
          idx_exp = exp_q.pop_front();
          chk("w_idx", 32'(W_IDX), 32'(idx_exp));
          chk("w_data", 32'(W_DATA), 32'(mem[idx_exp]));
          chk("w_last", 32'(W_LAST), 32'(idx_exp == DEPTH - 1));
          words++;
          if (exp_q.size() == 0) active = 1'b0;
        end
      end
      prev_stall = W_VALID && !W_READY;
      prev_idx = W_IDX;
      prev_data = W_DATA;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_sweep(input int budget);
    int n = 0;
    while (active && n < budget) begin
      tick();
      n++;
    end
    chk("sweep_timeout", 32'(active), 0);
    tick();
  endtask

  task automatic check_outputs_zero();
    chk("z_busy", 32'(BUSY), 0);
    chk("z_done", 32'(DONE), 0);
    chk("z_addr", 32'(BRAM_ADDR), 0);
    chk("z_en", 32'(BRAM_EN), 0);
    chk("z_valid", 32'(W_VALID), 0);
    chk("z_data", 32'(W_DATA), 0);
    chk("z_idx", 32'(W_IDX), 0);
    chk("z_last", 32'(W_LAST), 0);
  endtask

  initial begin
    RST = 1'b1;
    START = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    tick();
    tick();
    check_outputs_zero();
    RST = 1'b0;
    tick();

    // Full-rate sweep
    ready_mode = 0;
    tick();
    pulse_start();
    wait_sweep(100);
    chk("fr_first_valid", 32'(first_cyc - start_cyc), 2);
    chk("fr_done_cycle", 32'(done_cyc - start_cyc), 29);
    chk("fr_words", 32'(words), 28);
    chk("fr_dones", 32'(dones), 1);

    // Alternating ready
    ready_mode = 1;
    tick();
    pulse_start();
    wait_sweep(200);
    chk("tg_words", 32'(words), 28);
    chk("tg_dones", 32'(dones), 1);

    // Ready held low for 10 cycles after START
    ready_mode = 3;
    tick();
    tick();
    pulse_start();
    repeat (9) tick();
    chk("st_reads_le2", 32'(reads <= 2), 1);
    chk("st_valid", 32'(W_VALID), 1);
    chk("st_idx", 32'(W_IDX), 0);
    chk("st_data", 32'(W_DATA), 32'(mem[0]));
    ready_mode = 0;
    wait_sweep(200);
    chk("st_words", 32'(words), 28);
    chk("st_dones", 32'(dones), 1);

    // Second START mid-sweep is ignored
    tick();
    pulse_start();
    repeat (4) tick();
    pulse_start();
    wait_sweep(200);
    chk("dbl_words", 32'(words), 28);
    chk("dbl_dones", 32'(dones), 1);

    // Reset at cycle 10 of a sweep aborts it
    tick();
    pulse_start();
    repeat (9) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_outputs_zero();
    tick();
    chk("ab_valid_after", 32'(W_VALID), 0);
    chk("ab_en_after", 32'(BRAM_EN), 0);
    repeat (3) tick();
    pulse_start();
    wait_sweep(200);
    chk("ab_words", 32'(words), 28);
    chk("ab_dones", 32'(dones), 1);

    // START coinciding with DONE is not taken
    tick();
    pulse_start();
    repeat (28) tick();
    chk("dd_done_now", 32'(DONE), 1);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("dd_busy_gap", 32'(BUSY), 0);
    repeat (4) tick();
    chk("dd_no_restart", 32'(BUSY), 0);
    chk("dd_no_words", 32'(W_VALID), 0);

    // Randomized back-pressure sweeps with fresh BRAM contents
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      ready_mode = 2;
      repeat ($urandom_range(1, 4)) tick();
      pulse_start();
      wait_sweep(400);
      chk("rnd_words", 32'(words), 28);
      chk("rnd_dones", 32'(dones), 1);
      chk("rnd_first_valid", 32'(first_cyc - start_cyc), 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_fetch_seq.md
WEIGHT_FETCH_SEQ -- requirements
Module: weight_fetch_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 28, meaning number of weight words per BRAM.
REQ-002 SHALL have parameter AW, default 5, meaning BRAM address width.
REQ-003 SHALL have parameter DW, default 16, meaning weight word width.
REQ-004 SHALL have port CLK  input  1  single clock; BRAM samples on negedge CLK, this block uses posedge only.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port START  input  1  one-cycle pulse requesting a full sweep of addresses 0..DEPTH-1.
REQ-007 SHALL have port BUSY  output  1  high from accepted START until the last word handshakes.
REQ-008 SHALL have port DONE  output  1  one-cycle pulse on the cycle the last word handshakes.
REQ-009 SHALL have port BRAM_ADDR  output  AW  read address to the weight BRAM.
REQ-010 SHALL have port BRAM_EN  output  1  read enable to the weight BRAM.
REQ-011 SHALL have port BRAM_WE  output  1  write enable, constant 0.
REQ-012 SHALL have port BRAM_DI  output  DW  write data, constant 0.
REQ-013 SHALL have port BRAM_DO  input  DW  read data, valid at the posedge after the cycle EN was registered high.
REQ-014 SHALL have port W_DATA  output  DW  weight word to the neuron MAC.
REQ-015 SHALL have port W_IDX  output  AW  address the W_DATA word came from.
REQ-016 SHALL have port W_VALID  output  1  W_DATA/W_IDX/W_LAST valid.
REQ-017 SHALL have port W_READY  input  1  consumer accepts the word when W_VALID and W_READY are both high at posedge.
REQ-018 SHALL have port W_LAST  output  1  high with the word from address DEPTH-1.

Function
REQ-019 SHALL implement states IDLE, FETCH, DRAIN; IDLE->FETCH on START; FETCH->DRAIN after the read of DEPTH-1 is issued; DRAIN->IDLE on the handshake of the last word.
REQ-020 SHALL ignore START while BUSY is high.
REQ-021 SHALL register BRAM_ADDR and BRAM_EN; one read is issued per cycle that BRAM_EN is high, addresses strictly ascending from 0, no gaps and no repeats.
REQ-022 SHALL capture BRAM_DO at the posedge after issue into a 2-entry output FIFO tagged with its address.
REQ-023 SHALL issue a read only when (FIFO occupancy + reads in flight) < 2, so no word is ever dropped under back-pressure.
REQ-024 SHALL present W_DATA/W_IDX/W_LAST from the FIFO head, stable while W_VALID high and W_READY low.
REQ-025 SHALL, with W_READY held high, achieve 1 word/cycle throughput; first W_VALID two cycles after START; DONE DEPTH+1 cycles after START.
REQ-026 SHALL handle simultaneous FIFO push and pop in one cycle without occupancy change and without data corruption.
REQ-027 SHALL stop the address counter at DEPTH-1 (no wrap to 0) and hold BRAM_EN low in DRAIN and IDLE.
REQ-028 SHALL accept a START in the same cycle DONE pulses only on the following cycle (BUSY low for at least one cycle between sweeps).

Reset
REQ-029 SHALL, on RST high at posedge, enter IDLE, clear FIFO and in-flight tracking, and drive BRAM_ADDR=0, BRAM_EN=0, W_VALID=0, W_DATA=0, W_IDX=0, W_LAST=0, BUSY=0, DONE=0.
REQ-030 SHALL treat RST mid-sweep as abort: any BRAM_DO returning after reset is discarded; no DONE pulse.

Structure
REQ-031 SHALL take DEPTH, AW, DW and the state encoding from a shared package ann_weight_pkg used by all weight BRAM wrappers and fetchers.
REQ-032 SHALL place the 2-entry tagged FIFO in one sub-module, weight_skid_fifo.

Verification
REQ-033 Bench SHALL check: W_READY=1, START pulse -> 28 words idx 0..27 on consecutive cycles, W_LAST on idx 27, DONE at cycle START+29.
REQ-034 Bench SHALL check: W_READY toggling 1-0-1-0 -> every word delivered exactly once, in order, data matches BRAM contents.
REQ-035 Bench SHALL check: W_READY=0 for 10 cycles after START -> at most 2 reads issued, W_DATA holds idx 0 stable.
REQ-036 Bench SHALL check: second START at cycle 5 of a sweep -> ignored, exactly 28 words, one DONE.
REQ-037 Bench SHALL check: RST at cycle 10 of a sweep -> all outputs zero next cycle, no DONE, fresh START yields idx 0 first.
REQ-038 Bench SHALL check: BRAM_WE and BRAM_DI are 0 throughout all scenarios.
